// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: two-slot elastic buffer (main + skid) with
// valid/ready handshakes on both sides and a synchronous flush.
// in_ready_o comes straight from a flop, so EX back-pressure never ripples
// combinationally into ID.
// Optional feature macro: IDEX_WB_FWD_EN adds the write-back bus and patches
// held or captured operands whose source register is being written back.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [REG_ADDR_W-1:0] r1_addr_i,
    input  logic [REG_ADDR_W-1:0] r2_addr_i,
    input  logic [XLEN-1:0]       r1_data_i,
    input  logic [XLEN-1:0]       r2_data_i,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ALUOP_W-1:0]    aluop_o,
    output logic [ALUSEL_W-1:0]   alusel_o,
    output logic [XLEN-1:0]       r1_data_o,
    output logic [XLEN-1:0]       r2_data_o,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
`ifdef IDEX_WB_FWD_EN
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
`endif
    output logic [1:0]            occupancy_o
);

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
`ifdef IDEX_WB_FWD_EN
        logic [REG_ADDR_W-1:0] r1_addr;
        logic [REG_ADDR_W-1:0] r2_addr;
`endif
        logic [XLEN-1:0]       r1_data;
        logic [XLEN-1:0]       r2_data;
        logic                  w_enable;
        logic [REG_ADDR_W-1:0] w_addr;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

`ifndef IDEX_WB_FWD_EN
    // Source indices only matter for forwarding.
    logic unused_addr;
    assign unused_addr = ^{r1_addr_i, r2_addr_i};
`endif

    // Apply a same-cycle write-back to an entry's operands (identity without forwarding).
    function automatic entry_t fwd(input entry_t e);
        entry_t r;
        r = e;
`ifdef IDEX_WB_FWD_EN
        if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == e.r1_addr)) r.r1_data = wb_data_i;
        if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == e.r2_addr)) r.r2_data = wb_data_i;
`endif
        return r;
    endfunction

    assign in_ready_o = ~skid_valid_q;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_valid_q & out_ready_i;

    // Pack the incoming ID fields into an entry.
    always_comb begin
        in_entry          = '0;
        in_entry.aluop    = aluop_i;
        in_entry.alusel   = alusel_i;
`ifdef IDEX_WB_FWD_EN
        in_entry.r1_addr  = r1_addr_i;
        in_entry.r2_addr  = r2_addr_i;
`endif
        in_entry.r1_data  = r1_data_i;
        in_entry.r2_data  = r2_data_i;
        in_entry.w_enable = w_enable_i;
        in_entry.w_addr   = w_addr_i;
    end

    // Next-state for both slots; flush overrides everything.
    always_comb begin
        main_d       = fwd(main_q);
        skid_d       = fwd(skid_q);
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // FULL: in_ready_o is low, so only a dequeue can happen.
            if (out_fire) begin
                main_d       = fwd(skid_q);
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (in_fire && out_fire) begin
                main_d = fwd(in_entry);
            end else if (in_fire) begin
                skid_d       = fwd(in_entry);
                skid_valid_d = 1'b1;
            end else if (out_fire) begin
                main_d       = '0;
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            main_d       = fwd(in_entry);
            main_valid_d = 1'b1;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // EX sees a NOP (all zero) whenever the main slot is empty.
    always_comb begin
        out_valid_o = main_valid_q;
        aluop_o     = main_valid_q ? main_q.aluop    : '0;
        alusel_o    = main_valid_q ? main_q.alusel   : '0;
        r1_data_o   = main_valid_q ? main_q.r1_data  : '0;
        r2_data_o   = main_valid_q ? main_q.r2_data  : '0;
        w_enable_o  = main_valid_q ? main_q.w_enable : 1'b0;
        w_addr_o    = main_valid_q ? main_q.w_addr   : '0;
        occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [4:0]  r1_addr_i = '0;
    logic [4:0]  r2_addr_i = '0;
    logic [31:0] r1_data_i = '0;
    logic [31:0] r2_data_i = '0;
    logic        w_enable_i = 1'b0;
    logic [4:0]  w_addr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] r1_data_o;
    logic [31:0] r2_data_o;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [1:0]  occupancy_o;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;

    int n_checks = 0;
    int n_fail = 0;

    id_ex_pipe_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .r1_addr_i   (r1_addr_i),
        .r2_addr_i   (r2_addr_i),
        .r1_data_i   (r1_data_i),
        .r2_data_i   (r2_data_i),
        .w_enable_i  (w_enable_i),
        .w_addr_i    (w_addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .aluop_o     (aluop_o),
        .alusel_o    (alusel_o),
        .r1_data_o   (r1_data_o),
        .r2_data_o   (r2_data_o),
        .w_enable_o  (w_enable_o),
        .w_addr_o    (w_addr_o),
`ifdef IDEX_WB_FWD_EN
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
`endif
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an entry: rs1 index 5, rs2 index 6, alusel 3'b100, write enabled.
    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] wa);
        in_valid_i = v;
        aluop_i    = op;
        alusel_i   = 3'b100;
        r1_addr_i  = 5'd5;
        r2_addr_i  = 5'd6;
        r1_data_i  = d1;
        r2_data_i  = d2;
        w_enable_i = 1'b1;
        w_addr_i   = wa;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init: valid=%b occ=%0d rdy=%b want 0 0 1",
                     out_valid_o, occupancy_o, in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_i = 1'b0;
        drive(1'b1, 8'h20, 32'd1, 32'd2, 5'd1);
        step();
        drive(1'b1, 8'h21, 32'd3, 32'd4, 5'd2);
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_prefill_occ: got %0d want 2", occupancy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || r1_data_o !== 32'd0
            || aluop_o !== 8'd0 || w_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b occ=%0d r1=%h op=%h we=%b want all 0",
                     out_valid_o, occupancy_o, r1_data_o, aluop_o, w_enable_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready_o !== 1'b1 || occupancy_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b occ=%0d want 1 0", in_ready_o, occupancy_o);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h20 + 8'(i), 32'd5 + 32'(i), 32'd7 + 32'(i), 5'd3 + 5'(i));
            step();
            n_checks++;
            if (out_valid_o !== 1'b1 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_flow[%0d]: valid=%b occ=%0d rdy=%b want 1 1 1",
                         i, out_valid_o, occupancy_o, in_ready_o);
            end
            n_checks++;
            if (aluop_o !== 8'h20 + 8'(i) || r1_data_o !== 32'd5 + 32'(i)
                || r2_data_o !== 32'd7 + 32'(i) || w_addr_o !== 5'd3 + 5'(i)
                || alusel_o !== 3'b100 || w_enable_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_payload[%0d]: op=%h r1=%0d r2=%0d wa=%0d want %h %0d %0d %0d",
                         i, aluop_o, r1_data_o, r2_data_o, w_addr_o,
                         8'h20 + 8'(i), 5 + i, 7 + i, 3 + i);
            end
        end
        in_valid_i = 1'b0;
        step();
        n_checks++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: occ=%0d valid=%b want 0 0", occupancy_o, out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        drive(1'b1, 8'h30, 32'hA, 32'h1A, 5'd10);
        step();
        drive(1'b1, 8'h31, 32'hB, 32'h1B, 5'd11);
        step();
        drive(1'b1, 8'h32, 32'hC, 32'h1C, 5'd12);
        n_checks++;
        if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || r1_data_o !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_full: occ=%0d rdy=%b r1=%h want 2 0 a",
                     occupancy_o, in_ready_o, r1_data_o);
        end
        step();
        n_checks++;
        if (occupancy_o !== 2'd2 || r1_data_o !== 32'hA || aluop_o !== 8'h30) begin
            n_fail++;
            $display("FAIL bp_hold: occ=%0d r1=%h op=%h want 2 a 30",
                     occupancy_o, r1_data_o, aluop_o);
        end
        out_ready_i = 1'b1;
        step();
        n_checks++;
        if (r1_data_o !== 32'hB || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: r1=%h occ=%0d rdy=%b want b 1 1",
                     r1_data_o, occupancy_o, in_ready_o);
        end
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if (r1_data_o !== 32'hC || r2_data_o !== 32'h1C || occupancy_o !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_third: r1=%h r2=%h occ=%0d want c 1c 1",
                     r1_data_o, r2_data_o, occupancy_o);
        end
        step();
        n_checks++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: occ=%0d valid=%b want 0 0", occupancy_o, out_valid_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        drive(1'b1, 8'h40, 32'h40, 32'h41, 5'd4);
        step();
        drive(1'b1, 8'h41, 32'h42, 32'h43, 5'd5);
        step();
        drive(1'b1, 8'h42, 32'h44, 32'h45, 5'd6);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1
            || r1_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_full: occ=%0d valid=%b rdy=%b r1=%h want 0 0 1 0",
                     occupancy_o, out_valid_o, in_ready_o, r1_data_o);
        end
        drive(1'b1, 8'h43, 32'h46, 32'h47, 5'd7);
        step();
        drive(1'b1, 8'h44, 32'h48, 32'h49, 5'd8);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_infire: occ=%0d valid=%b want 0 0",
                     occupancy_o, out_valid_o);
        end
        out_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: valid=%b occ=%0d want 0 0", out_valid_o, occupancy_o);
        end
    endtask

    task automatic test_simultaneous();
        out_ready_i = 1'b1;
        drive(1'b1, 8'h50, 32'h50, 32'h51, 5'd9);
        step();
        n_checks++;
        if (occupancy_o !== 2'd1 || r1_data_o !== 32'h50) begin
            n_fail++;
            $display("FAIL simul_first: occ=%0d r1=%h want 1 50", occupancy_o, r1_data_o);
        end
        drive(1'b1, 8'h51, 32'h52, 32'h53, 5'd10);
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1 || r1_data_o !== 32'h52
            || aluop_o !== 8'h51 || w_addr_o !== 5'd10) begin
            n_fail++;
            $display("FAIL simul_swap: occ=%0d rdy=%b r1=%h op=%h wa=%0d want 1 1 52 51 10",
                     occupancy_o, in_ready_o, r1_data_o, aluop_o, w_addr_o);
        end
        step();
        n_checks++;
        if (aluop_o !== 8'd0 || w_enable_o !== 1'b0 || r2_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL simul_nop: op=%h we=%b r2=%h want 0 0 0",
                     aluop_o, w_enable_o, r2_data_o);
        end
    endtask

    task automatic test_forwarding();
        out_ready_i = 1'b0;
        drive(1'b1, 8'h60, 32'd11, 32'd22, 5'd1);
        step();
        in_valid_i = 1'b0;
        wb_we_i    = 1'b1;
        wb_addr_i  = 5'd5;
        wb_data_i  = 32'hDEADBEEF;
        step();
        wb_addr_i  = 5'd0;
        wb_data_i  = 32'h12345678;
`ifdef IDEX_WB_FWD_EN
        n_checks++;
        if (r1_data_o !== 32'hDEADBEEF || r2_data_o !== 32'd22) begin
            n_fail++;
            $display("FAIL fwd_hit: r1=%h r2=%h want deadbeef 16", r1_data_o, r2_data_o);
        end
        step();
        wb_we_i = 1'b0;
        n_checks++;
        if (r1_data_o !== 32'hDEADBEEF || r2_data_o !== 32'd22) begin
            n_fail++;
            $display("FAIL fwd_x0: r1=%h r2=%h want deadbeef 16", r1_data_o, r2_data_o);
        end
`else
        n_checks++;
        if (r1_data_o !== 32'd11 || r2_data_o !== 32'd22) begin
            n_fail++;
            $display("FAIL nofwd_hold: r1=%h r2=%h want b 16", r1_data_o, r2_data_o);
        end
        step();
        wb_we_i = 1'b0;
        n_checks++;
        if (r1_data_o !== 32'd11 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL nofwd_hold2: r1=%h valid=%b want b 1", r1_data_o, out_valid_o);
        end
`endif
        out_ready_i = 1'b1;
        step();
        n_checks++;
        if (occupancy_o !== 2'd0) begin
            n_fail++;
            $display("FAIL fwd_drain: occ=%0d want 0", occupancy_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_forwarding();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
